// File: rtl/ammrv_axi4lite_bridge_pkg.sv
// Shared types and constants for the Avalon-MM to AXI4-Lite bridge.
package ammrv_axi4lite_pkg;

    // Bridge sequencer states; exactly one command is in flight at a time.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        ACK   = 3'd5
    } state_e;

    // AXI response encodings, forwarded unchanged onto s_response.
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/ammrv_axi4lite_bridge_if.sv
// Bus bundles for the bridge: the Avalon-MM command side and the
// AXI4-Lite side. Each has a master and a slave view.

interface ammrv_avmm_if;
    logic [31:0] s_address;
    logic [3:0]  s_byteenable;
    logic [31:0] s_writedata;
    logic        s_read;
    logic        s_write;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic [1:0]  s_response;

    modport master (
        output s_address, s_byteenable, s_writedata, s_read, s_write,
        input  s_waitrequest, s_readdata, s_readdatavalid, s_response
    );

    modport slave (
        input  s_address, s_byteenable, s_writedata, s_read, s_write,
        output s_waitrequest, s_readdata, s_readdatavalid, s_response
    );
endinterface

interface ammrv_axil_if;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    modport master (
        output m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid,
               m_bready, m_araddr, m_arprot, m_arvalid, m_rready,
        input  m_awready, m_wready, m_bresp, m_bvalid, m_arready,
               m_rdata, m_rresp, m_rvalid
    );

    modport slave (
        input  m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid,
               m_bready, m_araddr, m_arprot, m_arvalid, m_rready,
        output m_awready, m_wready, m_bresp, m_bvalid, m_arready,
               m_rdata, m_rresp, m_rvalid
    );
endinterface

// File: rtl/ammrv_axi4lite_bridge.sv
// Avalon-MM slave to AXI4-Lite master bridge. One command in flight; all
// outputs are registered. Command in IDLE, then the address/data phase,
// the response phase and a one-cycle ACK where s_waitrequest drops.
// Read data is presented with s_readdatavalid the cycle after ACK.
module ammrv_axi4lite_bridge
    import ammrv_axi4lite_pkg::*;
#(
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic          clk,
    input  logic          areset,
    ammrv_avmm_if.slave   avs,
    ammrv_axil_if.master  axi
);

    state_e      state_r,   state_s;
    logic        awvalid_r, awvalid_s;
    logic        wvalid_r,  wvalid_s;
    logic        arvalid_r, arvalid_s;
    logic        bready_r,  bready_s;
    logic        rready_r,  rready_s;
    logic        waitreq_r, waitreq_s;
    logic        rdvalid_r, rdvalid_s;
    logic        is_read_r, is_read_s;
    logic [1:0]  resp_r,    resp_s;
    logic [31:0] rdata_r,   rdata_s;
    logic        cap_s;

    logic [31:0] addr_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;

    // Next-state and next-output decode for the command sequencer.
    always_comb begin
        state_s   = state_r;
        awvalid_s = awvalid_r;
        wvalid_s  = wvalid_r;
        arvalid_s = arvalid_r;
        bready_s  = 1'b0;
        rready_s  = 1'b0;
        waitreq_s = 1'b1;
        rdvalid_s = 1'b0;
        is_read_s = is_read_r;
        resp_s    = resp_r;
        rdata_s   = rdata_r;
        cap_s     = 1'b0;

        case (state_r)
            IDLE: begin
                // A simultaneous read is dropped: the write wins.
                if (avs.s_write) begin
                    cap_s     = 1'b1;
                    is_read_s = 1'b0;
                    awvalid_s = 1'b1;
                    wvalid_s  = 1'b1;
                    state_s   = WADDR;
                end else if (avs.s_read) begin
                    cap_s     = 1'b1;
                    is_read_s = 1'b1;
                    arvalid_s = 1'b1;
                    state_s   = RADDR;
                end else begin
                    state_s   = IDLE;
                end
            end

            WADDR: begin
                // AW and W complete independently, in either order.
                if (awvalid_r && axi.m_awready) begin
                    awvalid_s = 1'b0;
                end else begin
                    awvalid_s = awvalid_r;
                end
                if (wvalid_r && axi.m_wready) begin
                    wvalid_s = 1'b0;
                end else begin
                    wvalid_s = wvalid_r;
                end
                if (!awvalid_s && !wvalid_s) begin
                    bready_s = 1'b1;
                    state_s  = WRESP;
                end else begin
                    state_s  = WADDR;
                end
            end

            WRESP: begin
                if (axi.m_bvalid) begin
                    resp_s    = axi.m_bresp;
                    waitreq_s = 1'b0;
                    state_s   = ACK;
                end else begin
                    bready_s  = 1'b1;
                    state_s   = WRESP;
                end
            end

            RADDR: begin
                if (axi.m_arready) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                    state_s   = RDATA;
                end else begin
                    state_s   = RADDR;
                end
            end

            RDATA: begin
                if (axi.m_rvalid) begin
                    rdata_s   = axi.m_rdata;
                    resp_s    = axi.m_rresp;
                    waitreq_s = 1'b0;
                    state_s   = ACK;
                end else begin
                    rready_s  = 1'b1;
                    state_s   = RDATA;
                end
            end

            ACK: begin
                rdvalid_s = is_read_r;
                state_s   = IDLE;
            end

            default: begin
                awvalid_s = 1'b0;
                wvalid_s  = 1'b0;
                arvalid_s = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    // Control and status registers; reset abandons any command in flight.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_r   <= IDLE;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            arvalid_r <= 1'b0;
            bready_r  <= 1'b0;
            rready_r  <= 1'b0;
            waitreq_r <= 1'b1;
            rdvalid_r <= 1'b0;
            is_read_r <= 1'b0;
            resp_r    <= OKAY;
            rdata_r   <= 32'h0000_0000;
        end else begin
            state_r   <= state_s;
            awvalid_r <= awvalid_s;
            wvalid_r  <= wvalid_s;
            arvalid_r <= arvalid_s;
            bready_r  <= bready_s;
            rready_r  <= rready_s;
            waitreq_r <= waitreq_s;
            rdvalid_r <= rdvalid_s;
            is_read_r <= is_read_s;
            resp_r    <= resp_s;
            rdata_r   <= rdata_s;
        end
    end

    // Command payload capture; held stable for the whole transaction.
    always_ff @(posedge clk) begin
        if (cap_s) begin
            addr_r  <= avs.s_address;
            be_r    <= avs.s_byteenable;
            wdata_r <= avs.s_writedata;
        end
    end

    assign axi.m_awaddr  = addr_r;
    assign axi.m_awprot  = PROT;
    assign axi.m_awvalid = awvalid_r;
    assign axi.m_wdata   = wdata_r;
    assign axi.m_wstrb   = be_r;
    assign axi.m_wvalid  = wvalid_r;
    assign axi.m_bready  = bready_r;
    assign axi.m_araddr  = addr_r;
    assign axi.m_arprot  = PROT;
    assign axi.m_arvalid = arvalid_r;
    assign axi.m_rready  = rready_r;

    assign avs.s_waitrequest   = waitreq_r;
    assign avs.s_readdata      = rdata_r;
    assign avs.s_readdatavalid = rdvalid_r;
    assign avs.s_response      = resp_r;

endmodule

// File: tb/tb_ammrv_axi4lite_bridge.sv
// Bench for the Avalon-MM to AXI4-Lite bridge: directed and randomized
// commands against an AXI slave responder with programmable delays.
module tb_ammrv_axi4lite_bridge;

    logic clk;
    logic areset;
    int   checks;
    int   failures;

    logic [31:0] model_rdata;
    logic [1:0]  model_resp;

    ammrv_avmm_if avs_if ();
    ammrv_axil_if axi_if ();

    ammrv_axi4lite_bridge #(.PROT(3'b010)) dut (
        .clk    (clk),
        .areset (areset),
        .avs    (avs_if),
        .axi    (axi_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One Avalon command, with the AXI slave answering after the given delays.
    task automatic do_cmd(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input int ar_dly, input int r_dly,
                          input logic [31:0] rd_data, input logic [1:0] resp,
                          input bit abort, input bit chk_lat);
        int aw_hs, w_hs, b_hs, ar_hs, r_hs;
        int aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
        int low_cnt, first_low, rdv_cnt, unstable, post, ar_cycles, bad;
        bit aborted;
        bit exp_wr, exp_rd;
        bit p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
        logic [31:0] p_awaddr, p_wdata, p_araddr, rdv_data;
        logic [31:0] awaddr_seen, wdata_seen, araddr_seen;
        logic [3:0]  p_wstrb, wstrb_seen;
        logic [2:0]  prot_seen;

        exp_wr = wr;
        exp_rd = rd && !wr;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_cnt = 0; r_cnt = 0;
        low_cnt = 0; first_low = -1; rdv_cnt = 0; unstable = 0; post = 0;
        ar_cycles = 0; bad = 0; aborted = 1'b0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_bv = 0; p_br = 0;
        p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0;
        p_awaddr = 32'h0; p_wdata = 32'h0; p_araddr = 32'h0; p_wstrb = 4'h0;
        awaddr_seen = 32'h0; wdata_seen = 32'h0; araddr_seen = 32'h0;
        wstrb_seen = 4'h0; rdv_data = 32'h0; prot_seen = 3'b000;

        @(negedge clk);
        avs_if.s_address    = addr;
        avs_if.s_byteenable = be;
        avs_if.s_writedata  = wd;
        avs_if.s_write      = wr;
        avs_if.s_read       = rd;

        for (int cyc = 1; cyc <= 100 && post < 3; cyc++) begin
            @(negedge clk);
            if (p_awv && p_awr) aw_hs++;
            if (p_wv && p_wr) w_hs++;
            if (p_bv && p_br) b_hs++;
            if (p_arv && p_arr) ar_hs++;
            if (p_rv && p_rr) r_hs++;
            if (p_awv && !p_awr && (!axi_if.m_awvalid || axi_if.m_awaddr !== p_awaddr)) unstable++;
            if (p_wv && !p_wr && (!axi_if.m_wvalid || axi_if.m_wdata !== p_wdata || axi_if.m_wstrb !== p_wstrb)) unstable++;
            if (p_arv && !p_arr && (!axi_if.m_arvalid || axi_if.m_araddr !== p_araddr)) unstable++;
            if ((axi_if.m_awvalid && aw_hs > 0) || (axi_if.m_wvalid && w_hs > 0)) unstable++;
            if (axi_if.m_awvalid) begin awaddr_seen = axi_if.m_awaddr; prot_seen = axi_if.m_awprot; end
            if (axi_if.m_wvalid) begin wdata_seen = axi_if.m_wdata; wstrb_seen = axi_if.m_wstrb; end
            if (axi_if.m_arvalid) begin araddr_seen = axi_if.m_araddr; prot_seen = axi_if.m_arprot; ar_cycles++; end
            if (!avs_if.s_waitrequest) begin
                low_cnt++;
                if (first_low < 0) first_low = cyc;
                avs_if.s_write = 1'b0;
                avs_if.s_read  = 1'b0;
            end
            if (avs_if.s_readdatavalid) begin rdv_cnt++; rdv_data = avs_if.s_readdata; end
            if (first_low >= 0) post++;
            if (abort && axi_if.m_rready) begin
                aborted = 1'b1;
                break;
            end
            // Slave responder for the coming edge.
            if (axi_if.m_awvalid) begin axi_if.m_awready = (aw_wait >= aw_dly); aw_wait++; end
            else axi_if.m_awready = 1'b0;
            if (axi_if.m_wvalid) begin axi_if.m_wready = (w_wait >= w_dly); w_wait++; end
            else axi_if.m_wready = 1'b0;
            if (axi_if.m_arvalid) begin axi_if.m_arready = (ar_wait >= ar_dly); ar_wait++; end
            else axi_if.m_arready = 1'b0;
            axi_if.m_bvalid = (aw_hs > 0 && w_hs > 0 && b_hs == 0 && b_cnt >= b_dly);
            axi_if.m_bresp  = resp;
            if (aw_hs > 0 && w_hs > 0) b_cnt++;
            axi_if.m_rvalid = (ar_hs > 0 && r_hs == 0 && r_cnt >= r_dly);
            axi_if.m_rdata  = rd_data;
            axi_if.m_rresp  = resp;
            if (ar_hs > 0) r_cnt++;
            p_awv = axi_if.m_awvalid; p_awr = axi_if.m_awready; p_awaddr = axi_if.m_awaddr;
            p_wv = axi_if.m_wvalid; p_wr = axi_if.m_wready;
            p_wdata = axi_if.m_wdata; p_wstrb = axi_if.m_wstrb;
            p_bv = axi_if.m_bvalid; p_br = axi_if.m_bready;
            p_arv = axi_if.m_arvalid; p_arr = axi_if.m_arready; p_araddr = axi_if.m_araddr;
            p_rv = axi_if.m_rvalid; p_rr = axi_if.m_rready;
        end

        axi_if.m_awready = 1'b0;
        axi_if.m_wready  = 1'b0;
        axi_if.m_arready = 1'b0;
        axi_if.m_bvalid  = 1'b0;

        if (aborted) begin
            // Reset while the read waits for data, then a late rvalid.
            axi_if.m_rvalid = 1'b0;
            areset = 1'b1;
            avs_if.s_read = 1'b0;
            #1;
            chk("abort_rready", axi_if.m_rready, 1'b0);
            chk("abort_waitreq", avs_if.s_waitrequest, 1'b1);
            chk("abort_resp", avs_if.s_response, 2'b00);
            chk("abort_rdata", avs_if.s_readdata, 32'h0);
            model_rdata = 32'h0;
            model_resp  = 2'b00;
            @(negedge clk);
            areset = 1'b0;
            axi_if.m_rvalid = 1'b1;
            axi_if.m_rdata  = rd_data;
            axi_if.m_rresp  = resp;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (axi_if.m_rready || avs_if.s_readdatavalid || !avs_if.s_waitrequest) bad++;
            end
            axi_if.m_rvalid = 1'b0;
            chk("late_rvalid_ignored", bad, 0);
        end else begin
            axi_if.m_rvalid = 1'b0;
            if (exp_rd) model_rdata = rd_data;
            model_resp = resp;
            chk("completed", (first_low >= 0), 1'b1);
            chk("waitreq_low_cycles", low_cnt, 1);
            if (chk_lat) chk("latency", first_low, 3);
            chk("aw_handshakes", aw_hs, exp_wr);
            chk("w_handshakes", w_hs, exp_wr);
            chk("b_handshakes", b_hs, exp_wr);
            chk("ar_handshakes", ar_hs, exp_rd);
            chk("ar_ever_valid", (ar_cycles > 0), exp_rd);
            chk("valid_stability", unstable, 0);
            chk("prot", prot_seen, 3'b010);
            if (exp_wr) begin
                chk("awaddr", awaddr_seen, addr);
                chk("wdata", wdata_seen, wd);
                chk("wstrb", wstrb_seen, be);
            end else begin
                chk("araddr", araddr_seen, addr);
            end
            chk("readdatavalid_pulses", rdv_cnt, exp_rd);
            if (exp_rd) chk("readdatavalid_data", rdv_data, rd_data);
            chk("s_response", avs_if.s_response, model_resp);
            chk("s_readdata_hold", avs_if.s_readdata, model_rdata);
        end
    endtask

    initial begin
        int bad;
        checks = 0;
        failures = 0;
        model_rdata = 32'h0;
        model_resp = 2'b00;
        areset = 1'b1;
        avs_if.s_address = 32'h0; avs_if.s_byteenable = 4'h0; avs_if.s_writedata = 32'h0;
        avs_if.s_read = 1'b0; avs_if.s_write = 1'b0;
        axi_if.m_awready = 1'b0; axi_if.m_wready = 1'b0; axi_if.m_arready = 1'b0;
        axi_if.m_bresp = 2'b00; axi_if.m_bvalid = 1'b0;
        axi_if.m_rdata = 32'h0; axi_if.m_rresp = 2'b00; axi_if.m_rvalid = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_waitreq", avs_if.s_waitrequest, 1'b1);
        chk("rst_valids", {axi_if.m_awvalid, axi_if.m_wvalid, axi_if.m_arvalid}, 3'b000);
        chk("rst_readies", {axi_if.m_bready, axi_if.m_rready}, 2'b00);
        chk("rst_rdvalid", avs_if.s_readdatavalid, 1'b0);
        chk("rst_resp", avs_if.s_response, 2'b00);
        chk("rst_rdata", avs_if.s_readdata, 32'h0);
        areset = 1'b0;

        // Directed write, zero-delay slave.
        do_cmd(1'b1, 1'b0, 32'h1000_0004, 4'hC, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'h0, 2'b00, 1'b0, 1'b1);
        // Read with rvalid three cycles late and SLVERR.
        do_cmd(1'b0, 1'b1, 32'h2000_0000, 4'hF, 32'h0, 0, 0, 0, 0, 3, 32'h1234_5678, 2'b10, 1'b0, 1'b0);
        // Write with wready five cycles after awready; readdata must hold.
        do_cmd(1'b1, 1'b0, 32'h3000_0010, 4'h0, 32'hCAFE_F00D, 0, 5, 2, 0, 0, 32'h0, 2'b01, 1'b0, 1'b0);
        // AW late, W first.
        do_cmd(1'b1, 1'b0, 32'h3000_0020, 4'h5, 32'h0BAD_F00D, 4, 0, 0, 0, 0, 32'h0, 2'b11, 1'b0, 1'b0);
        // Read and write together: the write wins.
        do_cmd(1'b1, 1'b1, 32'h4000_0000, 4'hF, 32'h5555_AAAA, 0, 0, 0, 0, 0, 32'h0, 2'b00, 1'b0, 1'b1);
        // Zero-delay read latency.
        do_cmd(1'b0, 1'b1, 32'h4000_0008, 4'hF, 32'h0, 0, 0, 0, 0, 0, 32'h8765_4321, 2'b00, 1'b0, 1'b1);

        // Spurious bvalid/rvalid while idle must be ignored.
        @(negedge clk);
        bad = 0;
        axi_if.m_bvalid = 1'b1;
        axi_if.m_rvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (axi_if.m_bready || axi_if.m_rready || !avs_if.s_waitrequest || avs_if.s_readdatavalid) bad++;
        end
        axi_if.m_bvalid = 1'b0;
        axi_if.m_rvalid = 1'b0;
        chk("spurious_ignored", bad, 0);
        do_cmd(1'b1, 1'b0, 32'h5000_0000, 4'h3, 32'h0102_0304, 0, 0, 0, 0, 0, 32'h0, 2'b00, 1'b0, 1'b1);

        // Reset in RDATA, then an immediate read completes normally.
        do_cmd(1'b0, 1'b1, 32'h6000_0000, 4'hF, 32'h0, 0, 0, 0, 0, 20, 32'hFFFF_0000, 2'b00, 1'b1, 1'b0);
        do_cmd(1'b0, 1'b1, 32'h6000_0004, 4'hF, 32'h0, 0, 0, 0, 0, 0, 32'h0F0F_0F0F, 2'b01, 1'b0, 1'b1);

        // Randomized commands and slave delays.
        for (int n = 0; n < 12; n++) begin
            bit wr, rd;
            int d0, d1, d2, d3, d4;
            wr = $urandom_range(0, 1);
            rd = !wr || ($urandom_range(0, 3) == 0);
            d0 = $urandom_range(0, 4); d1 = $urandom_range(0, 4); d2 = $urandom_range(0, 4);
            d3 = $urandom_range(0, 4); d4 = $urandom_range(0, 4);
            do_cmd(wr, rd, $urandom, 4'($urandom_range(0, 15)), $urandom, d0, d1, d2, d3, d4,
                   $urandom, 2'($urandom_range(0, 3)), 1'b0,
                   (d0 == 0 && d1 == 0 && d2 == 0 && d3 == 0 && d4 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
